seq_alu: RTL and testbench

Parametrised WIDTH-bit ALU that supersedes the per-bit ripple slice with a registered, handshaked unit. Logic and arithmetic ops complete in one cycle, while shifts execute iteratively, one bit position per cycle. The block sits between the register-read stage and write-back and uses a valid/ready handshake on both sides. It adds SRA, status flags (zero, carry, overflow) and an illegal-opcode flag.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_comb.sv | 65 ++++++
 rtl/seq_alu.sv | 140 ++++++++++++++
 tb/tb_seq_alu.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states, result flags.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_RSV3 = 4'b0011,
        OP_NAND = 4'b0100,
        OP_NOR  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_SRL  = 4'b1001,
        OP_ADDU = 4'b1010,
        OP_SRA  = 4'b1011,
        OP_RSVC = 4'b1100,
        OP_RSVD = 4'b1101,
        OP_SUBU = 4'b1110,
        OP_SLTU = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    // Shifts are the only ops that take the multi-cycle path.
    function automatic logic is_shift(input alu_op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // Unassigned encodings; they still complete, flagged as illegal.
    function automatic logic is_reserved(input alu_op_e op);
        return (op == OP_RSV3) || (op == OP_RSVC) || (op == OP_RSVD);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational datapath: logic ops, add/sub with carry/overflow, SLT/SLTU.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to register the outputs.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             lt_s;
    logic             lt_u;

    // Shared adder: subtraction and both compares reuse a + ~b + 1.
    always_comb begin
        sub          = (op == OP_SUB) || (op == OP_SUBU) || (op == OP_SLT) || (op == OP_SLTU);
        b_eff        = sub ? ~b : b;
        {c_out, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        ovf          = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        // Signed less-than is N xor V of a-b; unsigned is a borrow (no carry).
        lt_s         = sum[WIDTH-1] ^ ovf;
        lt_u         = ~c_out;
    end

    // Result and flag selection per opcode.
    always_comb begin
        res      = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        illegal  = 1'b0;
        unique case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_NAND: res = ~(a & b);
            OP_NOR:  res = ~(a | b);
            OP_ADD, OP_SUB: begin
                res      = sum;
                carry    = c_out;
                overflow = ovf;
            end
            OP_ADDU, OP_SUBU: begin
                res   = sum;
                carry = c_out;
            end
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, lt_u};
            // A zero-distance shift completes here with the source unchanged.
            OP_SLL, OP_SRL, OP_SRA: res = a;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU: 1-cycle logic/arith ops, shifts iterate one bit per cycle.
// Latency: 1 cycle for non-shift ops, n+1 cycles for a shift by n (n >= 1).
// Backpressure: result and flags hold while out_ready=0; in_ready drops during shifts and stalls.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic             illegal
);

    state_e           state_q;
    alu_op_e          op_q;
    logic [WIDTH-1:0] shreg_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             carry_q;
    logic             ovf_q;
    logic             illegal_q;
    logic             out_valid_q;

    alu_op_e          op_in;
    logic [SHW-1:0]   amt;
    logic             accept;
    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] c_res;
    logic             c_carry;
    logic             c_ovf;
    logic             c_illegal;

    assign op_in  = alu_op_e'(alu_op);
    assign amt    = b[SHW-1:0];
    // DONE with a consumer taking the result frees the slot in the same cycle.
    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle ops are evaluated straight off the request inputs.
    alu_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .a        (a),
        .b        (b),
        .op       (op_in),
        .res      (c_res),
        .carry    (c_carry),
        .overflow (c_ovf),
        .illegal  (c_illegal)
    );

    // One-bit step of the in-flight shift; SRA refills from the sign bit.
    always_comb begin
        shift_d = shreg_q;
        unique case (op_q)
            OP_SLL:  shift_d = {shreg_q[WIDTH-2:0], 1'b0};
            OP_SRL:  shift_d = {1'b0, shreg_q[WIDTH-1:1]};
            OP_SRA:  shift_d = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
            default: shift_d = shreg_q;
        endcase
    end

    // Control FSM plus the registered result, flags and shift state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_AND;
            shreg_q     <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            op_q    <= op_in;
            shreg_q <= a;
            cnt_q   <= amt;
            if (is_shift(op_in) && (amt != '0)) begin
                state_q     <= ST_SHIFT;
                out_valid_q <= 1'b0;
            end else begin
                state_q     <= ST_DONE;
                out_valid_q <= 1'b1;
                result_q    <= c_res;
                zero_q      <= (c_res == '0);
                carry_q     <= c_carry;
                ovf_q       <= c_ovf;
                illegal_q   <= c_illegal;
            end
        end else begin
            unique case (state_q)
                ST_SHIFT: begin
                    shreg_q <= shift_d;
                    cnt_q   <= cnt_q - 1'b1;
                    // Last step: publish the shifted value directly.
                    if (cnt_q == SHW'(1)) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= shift_d;
                        zero_q      <= (shift_d == '0);
                        carry_q     <= 1'b0;
                        ovf_q       <= 1'b0;
                        illegal_q   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_IDLE: ;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboarded bench for seq_alu: directed corner cases, randomized traffic, reset abort.
// Latency: checked for 1-cycle ops and shifts.
// Backpressure: random out_ready stalls with hold checks on every stalled cycle.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [3:0]  alu_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        carry_out;
    logic        overflow;
    logic        illegal;

    seq_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry_out (carry_out),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
        logic        il;
    } exp_t;

    exp_t sb_q[$];
    int   errs = 0;
    int   checks = 0;
    logic rnd_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model written from the ISA rules using wide integer arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        exp_t   e;
        longint sx;
        longint sy;
        longint ux;
        longint uy;
        longint s;
        int     n;
        e  = '0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'h0, x});
        uy = longint'({32'h0, y});
        n  = int'(y[4:0]);
        case (op)
            4'h0: e.res = x & y;
            4'h1: e.res = x | y;
            4'h4: e.res = ~(x & y);
            4'h5: e.res = ~(x | y);
            4'h2, 4'hA: begin
                e.res = x + y;
                e.c   = (ux + uy) > 64'sd4294967295;
                s     = sx + sy;
                e.v   = (op == 4'h2) && (s != longint'($signed(e.res)));
            end
            4'h6, 4'hE: begin
                e.res = x - y;
                e.c   = (x >= y);
                s     = sx - sy;
                e.v   = (op == 4'h6) && (s != longint'($signed(e.res)));
            end
            4'h7: e.res = (sx < sy) ? 32'd1 : 32'd0;
            4'hF: e.res = (x < y) ? 32'd1 : 32'd0;
            4'h8: e.res = x << n;
            4'h9: e.res = x >> n;
            4'hB: e.res = 32'($signed(x) >>> n);
            default: begin
                e.res = '0;
                e.il  = 1'b1;
            end
        endcase
        e.z = (e.res == 32'h0);
        return e;
    endfunction

    // Monitor: pops the scoreboard on each handshake and checks stalls hold outputs.
    logic        stall_q = 1'b0;
    logic [35:0] held = '0;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_valid", {63'h0, out_valid}, 64'h1);
                check("stall_hold", {28'h0, result, zero, carry_out, overflow, illegal}, {28'h0, held});
            end
            if (out_valid) begin
                if (out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_out_valid", {63'h0, out_valid}, 64'h0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("result", {32'h0, result}, {32'h0, mon_e.res});
                        check("flags", {60'h0, zero, carry_out, overflow, illegal},
                              {60'h0, mon_e.z, mon_e.c, mon_e.v, mon_e.il});
                    end
                end
                stall_q = !out_ready;
                held    = {result, zero, carry_out, overflow, illegal};
            end else begin
                stall_q = 1'b0;
            end
        end
    end

    // Present a request, wait (bounded) for acceptance, then scramble the inputs.
    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        logic got;
        got    = 1'b0;
        alu_op = op;
        a      = x;
        b      = y;
        in_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (got) sb_q.push_back(model(op, x, y));
        else check("issue_timeout", {63'h0, in_ready}, 64'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        alu_op   = 4'($urandom);
    endtask

    // Count negedges after the accept edge until out_valid shows.
    task automatic wait_valid(output int lat, input logic chk_busy);
        lat = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (chk_busy) check("in_ready_busy", {63'h0, in_ready}, 64'h0);
        end
    endtask

    // Hold the result for some cycles, then take it.
    task automatic retire(input int stall);
        repeat (stall + 1) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    int          lat;
    int          c0;
    int          vcount;
    logic [31:0] ra;
    logic [31:0] rb;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_result", {32'h0, result}, 64'h0);
        check("rst_flags", {60'h0, zero, carry_out, overflow, illegal}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", {63'h0, in_ready}, 64'h1);

        // Signed overflow on ADD, one-cycle latency, 3-cycle stall
        issue(4'h2, 32'h7FFF_FFFF, 32'h1);
        wait_valid(lat, 1'b0);
        check("lat_add", 64'(lat), 64'd1);
        retire(3);

        // SUBU equal operands, then SLTU
        issue(4'hE, 32'd5, 32'd5);
        wait_valid(lat, 1'b0);
        retire(0);
        issue(4'hF, 32'd1, 32'hFFFF_FFFF);
        wait_valid(lat, 1'b0);
        retire(1);

        // SRA by 4: busy for the shift, result after 5
        issue(4'hB, 32'h8000_0000, 32'd4);
        wait_valid(lat, 1'b1);
        check("lat_sra4", 64'(lat), 64'd5);
        retire(0);

        // SLL with zero amount (upper b bits ignored)
        issue(4'h8, 32'h1234_5678, 32'h20);
        wait_valid(lat, 1'b0);
        check("lat_sll0", 64'(lat), 64'd1);
        retire(0);

        // Reserved opcode
        issue(4'hC, 32'hDEAD_BEEF, 32'h1234_5678);
        wait_valid(lat, 1'b0);
        retire(0);

        // Back-to-back issue with consumer always ready
        out_ready = 1'b1;
        c0 = cyc;
        issue(4'h0, 32'hF0F0_F0F0, 32'hFF00_FF00);
        issue(4'h1, 32'h0F0F_0000, 32'h0000_1234);
        issue(4'h5, 32'h0, 32'h0);
        check("b2b_cycles", 64'(cyc - c0), 64'd3);
        check("b2b_valid", {63'h0, out_valid}, 64'h1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Randomized traffic with random backpressure
        fork
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            ra = pick();
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : pick();
            issue(4'($urandom_range(0, 15)), ra, rb);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_done = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
        end
        check("drain", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of an SRL by 20 discards the op
        issue(4'h9, 32'hCAFE_F00D, 32'd20);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("abort_out_valid", {63'h0, out_valid}, 64'h0);
        check("abort_result", {32'h0, result}, 64'h0);
        check("abort_in_ready", {63'h0, in_ready}, 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        vcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check("abort_no_valid", 64'(vcount), 64'd0);
        @(posedge clk);
        #1;

        // Block is usable again after the abort
        out_ready = 1'b0;
        issue(4'h6, 32'h8000_0000, 32'h1);
        wait_valid(lat, 1'b0);
        check("lat_post_rst", 64'(lat), 64'd1);
        retire(0);
        check("final_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
